instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
// - Sequential instruction fetcher sitting directly upstream of the program ROM interface.
// - Drives word addresses and read requests into the ROM interface; captures returned words in a prefetch FIFO.
// - Presents {instr_pc, instr_data} to the decoder over a valid/ready handshake.
// - Supports PC redirect (branch/jump/trap) with flush of queued and in-flight words.
// PARAMETERS
// - FIFO_DEPTH  4      prefetch entries; power of 2, >=2; >=4 required for 1 instr/cycle sustained
// - RESET_PC    32'h0  fetch PC loaded on reset; bits [1:0] must be 0
// PORTS
// - clk                  in   1   single clock, all state on posedge
// - reset                in   1   synchronous, active-high reset
// - redirect             in   1   load new fetch PC, flush all pending fetch state
// - redirect_pc          in   32  target PC; bits [1:0] ignored (treated as 0)
// - instr_valid          out  1   FIFO head holds a valid instruction
// - instr_ready          in   1   decoder accepts head this cycle
// - instr_data           out  32  instruction word at FIFO head
// - instr_pc             out  32  PC of instruction at FIFO head
// - rom_addr             out  12  word address to ROM interface = fetch_pc[13:2]
// - rom_read_req         out  1   read request to ROM interface
// - rom_read_data        in   32  ROM data, valid when rom_read_data_valid
// - rom_read_data_valid  in   1   asserted exactly 1 cycle after an accepted rom_read_req
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC; FIFO empty; in_flight=0; kill=0; instr_valid=0; rom_read_req=0.
//   instr_data/instr_pc are don't-care while instr_valid=0; FIFO storage is not reset.
// - Issue rule:
//   - rom_read_req = !reset && !redirect && (count + in_flight < FIFO_DEPTH).
//   - Combinational from registered count/in_flight; a same-cycle pop gives no credit.
// - On issue:
//   - rom_addr = fetch_pc[13:2].
//   - req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4, wrapping mod 2^32.
//   - in_flight <= 1; otherwise in_flight <= 0.
// - Response: rom_read_data_valid && !kill -> push {req_pc, rom_read_data} to FIFO tail.
//   - Responses with kill=1 are dropped.
//   - kill clears the cycle after it is consumed.
// - Latency: rom_read_req at cycle T -> word pushed at T+1 -> instr_valid visible at T+2.
//   - After reset or redirect, the first instr_valid is 3 cycles after the event cycle.
// - Handshake:
//   - Pop occurs when instr_valid && instr_ready.
//   - instr_valid, instr_data and instr_pc are registered FIFO-head outputs, held stable until popped.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
// - Full: push is never attempted when full; this is guaranteed by the issue rule.
//   - Assertion: push while count==FIFO_DEPTH is an error.
// - Empty: instr_valid=0; instr_ready is ignored.
// - Redirect at cycle T (priority over issue):
//   - A pop handshake in cycle T still completes; the decoder owns that word.
//   - Then FIFO count<=0, pointers reset.
//   - kill<=in_flight, so the response arriving at T+1 is dropped.
//   - fetch_pc <= {redirect_pc[31:2],2'b00}; no rom_read_req in T; issuing resumes at T+1.
//   - Back-to-back redirects: the last one wins; each flushes again.
// - Redirect and reset in the same cycle: reset wins.
// - Reset mid-operation: all state returns to reset values; a ROM response in the following cycle is ignored (in_flight=0, kill=0, no push).
// - ROM address wrap: fetch_pc bits above 13 are carried in instr_pc but do not affect rom_addr.
//   - 0x3FFC -> 0x4000 gives rom_addr 0xFFF -> 0x000.
// CONFIGURATION
// - INSTRUCTION_FETCH_STATS_EN defined:
//   - Adds output ports stat_fetched[31:0] (count of pushes) and stat_stall[31:0].
//   - stat_stall counts cycles with instr_valid=0 && !reset && !redirect.
//   - Both counters clear on reset and wrap at 2^32.
// - Not defined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Reset then instr_ready=1 constant, RESET_PC=0:
//   - instr_pc 0x0,0x4,0x8,... on consecutive cycles from cycle 3.
//   - instr_data equals ROM words 0,1,2.
// - instr_ready=0 for 20 cycles:
//   - rom_read_req stops with count=4, in_flight=0; instr_valid stays 1, head stable at pc 0x0.
//   - Release ready -> pcs 0x0..0xC, then 0x10 follow without gaps.
// - Redirect to 0x100 while a request for 0x20 is in flight:
//   - The 0x20 word is never presented.
//   - Next instr_pc is 0x100, 3 cycles after redirect.
// - Redirect with redirect_pc=0x203 in the same cycle as a pop of pc 0x40:
//   - pc 0x40 is consumed once; the next presented pc is 0x200.
// - Issue at fetch_pc=0x3FFC:
//   - rom_addr 0xFFF, then 0x000; instr_pc values 0x3FFC then 0x4000.
// - Reset asserted with FIFO holding 3 entries and 1 in flight:
//   - instr_valid=0 next cycle; no stray push.
//   - Fetch restarts at RESET_PC.
//   - With INSTRUCTION_FETCH_STATS_EN, stat_fetched=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Sequential instruction fetcher: issues ROM word reads, buffers returns in a prefetch FIFO,
// presents registered {instr_pc, instr_data} over valid/ready. Optional: INSTRUCTION_FETCH_STATS_EN.
module instruction_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [11:0] rom_addr,
  output logic        rom_read_req,
  input  logic [31:0] rom_read_data,
  input  logic        rom_read_data_valid
`ifdef INSTRUCTION_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             in_flight_q, in_flight_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] count_q, count_d, count_after_pop;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [31:0]      head_pc_q, head_pc_d;
  logic [31:0]      head_data_q, head_data_d;
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic             issue, push, pop, mem_we;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    // Credit is taken from registered occupancy only; a pop this cycle frees nothing yet.
    issue           = !reset && !redirect && ((count_q + CNT_W'(in_flight_q)) < DEPTH_C);
    push            = rom_read_data_valid && in_flight_q && !kill_q;
    pop             = valid_q && instr_ready;
    mem_we          = push && !redirect && !reset;
    count_after_pop = count_q - CNT_W'(pop);

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = issue;
    kill_d      = redirect && in_flight_q;
    count_d     = count_after_pop + CNT_W'(push);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    valid_d     = (count_d != '0);

    // Head register bypasses the storage when the pushed word becomes the new head.
    if (push && (count_after_pop == '0)) begin
      head_pc_d   = req_pc_q;
      head_data_d = rom_read_data;
    end else begin
      head_pc_d   = mem_q[rd_ptr_d][63:32];
      head_data_d = mem_q[rd_ptr_d][31:0];
    end

    if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      in_flight_q <= 1'b0;
      kill_q      <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      valid_q     <= 1'b0;
      head_pc_q   <= '0;
      head_data_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
      kill_q      <= kill_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_q     <= valid_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {req_pc_q, rom_read_data};
  end

  assign rom_read_req = issue;
  assign rom_addr     = fetch_pc_q[13:2];
  assign instr_valid  = valid_q;
  assign instr_pc     = head_pc_q;
  assign instr_data   = head_data_q;

  assert property (@(posedge clk) disable iff (reset) !(push && (count_q == DEPTH_C)))
    else $error("instruction_fetch: push into full prefetch FIFO");

`ifdef INSTRUCTION_FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(mem_we);
    stat_stall_d   = stat_stall_q + 32'(!valid_q && !redirect);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, directed redirect/wrap/reset sequences, and a
// randomized run against a stream-level reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, redirect, instr_valid, instr_ready, rom_read_req, rom_read_data_valid;
  logic [31:0] redirect_pc, instr_data, instr_pc, rom_read_data;
  logic [11:0] rom_addr;
`ifdef INSTRUCTION_FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit inject = 1'b0;
  int seen_20, seen_40;

  localparam logic [31:0] RST_PC = 32'h0;

  always #5 clk = ~clk;

  instruction_fetch #(.FIFO_DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .rom_addr(rom_addr), .rom_read_req(rom_read_req),
    .rom_read_data(rom_read_data), .rom_read_data_valid(rom_read_data_valid)
`ifdef INSTRUCTION_FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit rst, input bit rdy, input bit rd, input logic [31:0] rpc);
    reset = rst; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #2;
  endtask

  // ROM model: a request seen before the edge is answered for the whole next cycle.
  task automatic step();
    logic        r;
    logic [11:0] a;
    r = rom_read_req;
    a = rom_addr;
    @(posedge clk);
    #1;
    rom_read_data_valid = r || inject;
    rom_read_data       = rom_word(a);
    inject              = 1'b0;
  endtask

  task automatic note_pop();
    if (instr_valid && instr_ready) begin
      if (instr_pc == 32'h20) seen_20++;
      if (instr_pc == 32'h40) seen_40++;
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          exp_req;
    logic [11:0] exp_addr;
    bit          chk_valid;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit rdy, input bit req, input logic [11:0] addr,
                              input bit chkv, input bit v, input logic [31:0] pc);
    vec_t e;
    e.rst = rst; e.rdy = rdy; e.exp_req = req; e.exp_addr = addr;
    e.chk_valid = chkv; e.exp_valid = v; e.exp_pc = pc;
    vecs.push_back(e);
  endfunction

  initial begin
    bit          found, hit, rst, rd, rdy, exp_req, pop, hold;
    logic [31:0] rpc, m_fetch, m_exp, prev_pc, prev_data;
    int          m_out;

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    rom_read_data = '0; rom_read_data_valid = 1'b0;
    seen_20 = 0; seen_40 = 0;

    // Streaming after reset with ready held high.
    add(1, 1, 0, 12'h000, 1, 0, 32'h0);
    add(0, 1, 1, 12'h000, 1, 0, 32'h0);
    add(0, 1, 1, 12'h001, 1, 0, 32'h0);
    add(0, 1, 1, 12'h002, 1, 1, 32'h0);
    add(0, 1, 1, 12'h003, 1, 1, 32'h4);
    add(0, 1, 1, 12'h004, 1, 1, 32'h8);
    // Reset mid-stream, then 20+ cycles of backpressure until the FIFO fills.
    add(1, 0, 0, 12'h000, 0, 0, 32'h0);
    add(0, 0, 1, 12'h000, 1, 0, 32'h0);
    add(0, 0, 1, 12'h001, 1, 0, 32'h0);
    add(0, 0, 1, 12'h002, 1, 1, 32'h0);
    add(0, 0, 1, 12'h003, 1, 1, 32'h0);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 12'h000, 1, 1, 32'h0);
    add(0, 1, 0, 12'h000, 1, 1, 32'h0);
    add(0, 1, 1, 12'h004, 1, 1, 32'h4);
    add(0, 1, 1, 12'h005, 1, 1, 32'h8);
    add(0, 1, 1, 12'h006, 1, 1, 32'hC);
    add(0, 1, 1, 12'h007, 1, 1, 32'h10);

    apply(1, 1, 0, 0); step();
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].rdy, 0, 0);
      checkb($sformatf("vec%0d_req", i), rom_read_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].chk_valid) begin
        checkb($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid);
        if (vecs[i].exp_valid) begin
          check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
          check($sformatf("vec%0d_data", i), instr_data, rom_word(vecs[i].exp_pc[13:2]));
        end
      end
      step();
    end

    // Redirect to 0x100 while the 0x20 request is in flight.
    apply(1, 1, 0, 0); step();
    seen_20 = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      apply(0, 1, 0, 0);
      note_pop();
      hit = rom_read_req && (rom_addr == 12'h008);
      step();
      if (hit) found = 1'b1;
    end
    checkb("seq1_reach_0x20", found, 1'b1);
    apply(0, 1, 1, 32'h100);
    checkb("seq1_req_in_redirect", rom_read_req, 1'b0);
    note_pop(); step();
    apply(0, 1, 0, 0);
    checkb("seq1_req_t1", rom_read_req, 1'b1);
    check("seq1_addr_t1", 32'(rom_addr), 32'h40);
    checkb("seq1_valid_t1", instr_valid, 1'b0);
    step();
    apply(0, 1, 0, 0);
    checkb("seq1_valid_t2", instr_valid, 1'b0);
    step();
    apply(0, 1, 0, 0);
    checkb("seq1_valid_t3", instr_valid, 1'b1);
    check("seq1_pc_t3", instr_pc, 32'h100);
    check("seq1_data_t3", instr_data, rom_word(12'h040));
    note_pop(); step();
    for (int i = 0; i < 6; i++) begin apply(0, 1, 0, 0); note_pop(); step(); end
    check("seq1_0x20_never_seen", seen_20, 0);

    // Redirect to 0x203 in the same cycle that pc 0x40 is popped.
    apply(1, 1, 0, 0); step();
    seen_40 = 0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      apply(0, 1, 0, 0);
      if (instr_valid && (instr_pc == 32'h40)) begin
        found = 1'b1; redirect = 1'b1; redirect_pc = 32'h203; #1;
      end
      note_pop(); step();
    end
    checkb("seq2_reach_0x40", found, 1'b1);
    apply(0, 1, 0, 0);
    checkb("seq2_valid_t1", instr_valid, 1'b0);
    step();
    apply(0, 1, 0, 0);
    checkb("seq2_valid_t2", instr_valid, 1'b0);
    step();
    apply(0, 1, 0, 0);
    checkb("seq2_valid_t3", instr_valid, 1'b1);
    check("seq2_pc_t3", instr_pc, 32'h200);
    note_pop(); step();
    check("seq2_0x40_once", seen_40, 1);

    // ROM address wrap across 0x3FFC -> 0x4000.
    apply(1, 1, 0, 0); step();
    for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0); step(); end
    apply(0, 1, 1, 32'h3FFC); step();
    apply(0, 1, 0, 0);
    checkb("seq3_req_a", rom_read_req, 1'b1);
    check("seq3_addr_a", 32'(rom_addr), 32'hFFF);
    step();
    apply(0, 1, 0, 0);
    checkb("seq3_req_b", rom_read_req, 1'b1);
    check("seq3_addr_b", 32'(rom_addr), 32'h000);
    step();
    apply(0, 1, 0, 0);
    check("seq3_pc_a", instr_pc, 32'h3FFC);
    check("seq3_data_a", instr_data, rom_word(12'hFFF));
    step();
    apply(0, 1, 0, 0);
    check("seq3_pc_b", instr_pc, 32'h4000);
    check("seq3_data_b", instr_data, rom_word(12'h000));
    step();

    // Reset with 3 queued entries and one in flight, plus a stray response right after.
    apply(1, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin apply(0, 0, 0, 0); step(); end
    apply(1, 0, 0, 0);
    checkb("seq4_req_in_reset", rom_read_req, 1'b0);
    inject = 1'b1;
    step();
    apply(0, 0, 0, 0);
    checkb("seq4_valid_r1", instr_valid, 1'b0);
    checkb("seq4_req_r1", rom_read_req, 1'b1);
    check("seq4_addr_r1", 32'(rom_addr), 32'(RST_PC[13:2]));
`ifdef INSTRUCTION_FETCH_STATS_EN
    check("seq4_stat_fetched", stat_fetched, 32'h0);
`endif
    step();
    apply(0, 0, 0, 0);
    checkb("seq4_no_stray_push", instr_valid, 1'b0);
    step();
    apply(0, 0, 0, 0);
    checkb("seq4_valid_r3", instr_valid, 1'b1);
    check("seq4_pc_r3", instr_pc, RST_PC);
    check("seq4_data_r3", instr_data, rom_word(RST_PC[13:2]));
    step();

    // Randomized run: expected stream of PCs plus outstanding-word credit accounting.
    apply(1, 0, 0, 0); step();
    m_fetch = RST_PC; m_exp = RST_PC; m_out = 0; hold = 1'b0;
    prev_pc = '0; prev_data = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 1) rpc[31:14] = '0;
      rdy = ($urandom_range(0, 3) != 0);
      apply(rst, rdy, rd, rpc);
      exp_req = !rst && !rd && (m_out < 4);
      checkb("rnd_req", rom_read_req, exp_req);
      if (exp_req) check("rnd_addr", 32'(rom_addr), 32'(m_fetch[13:2]));
      if (rst) begin
        m_fetch = RST_PC; m_exp = RST_PC; m_out = 0; hold = 1'b0;
      end else begin
        if (hold) begin
          checkb("rnd_hold_valid", instr_valid, 1'b1);
          check("rnd_hold_pc", instr_pc, prev_pc);
          check("rnd_hold_data", instr_data, prev_data);
        end
        pop = instr_valid && rdy;
        if (pop) begin
          check("rnd_pop_pc", instr_pc, m_exp);
          check("rnd_pop_data", instr_data, rom_word(m_exp[13:2]));
          m_exp = m_exp + 32'd4;
        end
        hold = instr_valid && !pop && !rd;
        prev_pc = instr_pc; prev_data = instr_data;
        if (rd) begin
          m_fetch = {rpc[31:2], 2'b00}; m_exp = m_fetch; m_out = 0;
        end else begin
          m_out = m_out + int'(exp_req) - int'(pop);
          if (exp_req) m_fetch = m_fetch + 32'd4;
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
